riscv_run_monitor: RTL

// - Parametrised run controller and monitor for the pipelined RISC_V core.
// - Replaces fixed clock-count simulation control. Releases the core reset after a

---
 rtl/riscv_run_monitor.sv | 102 ++++++++++
 1 files changed

// File: rtl/riscv_run_monitor.sv
// Run controller / monitor for the pipelined RISC_V core: holds the core in reset,
// then counts events and flags done / timeout / hang. Optional: RUN_MONITOR_SIGNATURE_EN.
module riscv_run_monitor #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int RST_HOLD    = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 8,
  parameter logic [XLEN-1:0] END_PC = 32'h0000_0040
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PC_EX,
  input  logic             PCSrc,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic             pipeline_stall,
  output logic             core_rst,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [XLEN-1:0]  signature,
  output logic             done,
  output logic             timeout,
  output logic             hang
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {HOLD, RUN, DONE, TOUT, HANG} state_t;

  state_t         state, state_nxt;
  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  stall_run;
  logic           hold_last, hang_hit, done_hit, tout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Compare in 32 bits so a narrow CNT_W never aliases MAX_CYCLES-1.
  always_comb begin
    hold_last = (32'(hold_cnt) == RST_HOLD - 1);
    hang_hit  = pipeline_stall && (32'(stall_run) == STALL_LIMIT - 1);
    done_hit  = (PC_EX == END_PC);
    tout_hit  = (32'(cycle_cnt) == MAX_CYCLES - 1);
    state_nxt = state;
    case (state)
      HOLD:    if (hold_last) state_nxt = RUN;
      RUN: begin
        if (hang_hit)      state_nxt = HANG;
        else if (done_hit) state_nxt = DONE;
        else if (tout_hit) state_nxt = TOUT;
      end
      default: state_nxt = state;
    endcase
  end

  assign core_rst = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      stall_run  <= '0;
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      branch_cnt <= '0;
      fwd_cnt    <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      hang       <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= (state_nxt == DONE);
      timeout <= (state_nxt == TOUT);
      hang    <= (state_nxt == HANG);
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == RUN) begin
        cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
        stall_cnt  <= sat_inc(stall_cnt, pipeline_stall);
        branch_cnt <= sat_inc(branch_cnt, PCSrc);
        fwd_cnt    <= sat_inc(fwd_cnt, |{forwardA, forwardB});
        stall_run  <= pipeline_stall ? stall_run + 1'b1 : '0;
      end
    end
  end

`ifdef RUN_MONITOR_SIGNATURE_EN
  logic [XLEN-1:0] sig_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            sig_q <= '0;
    else if (state == RUN) sig_q <= {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ PC_EX;
  end
  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule
